addsub_accum: RTL and testbench

- Registered accumulator stage downstream of the 4-bit adder/subtractor datapath.
- Each accepted operand is added to or subtracted from a running accumulator. The result and its carry/borrow/zero/saturation flags are captured in a one-entry output buffer with valid/ready handshaking.
- Provides the sequential result-capture stage that the combinational add/sub cells feed.

---
 rtl/addsub_accum.sv | 85 ++++++++
 tb/tb_addsub_accum.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/addsub_accum.sv
// Add/subtract accumulator with a one-entry result buffer; result and flags appear one cycle after accept.
// Stalls (in_ready=0) while a result is held unconsumed or a clear is in progress.
module addsub_accum #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc,
  output logic             carry,
  output logic             borrow,
  output logic             zero,
  output logic             sat,
  output logic [CNT_W-1:0] op_cnt
);

  logic             accept;
  logic             consume;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   dif_ext;
  logic [WIDTH-1:0] res_acc;
  logic             res_carry;
  logic             res_borrow;
  logic             res_sat;

  assign in_ready = !clr && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  // The extra MSB of the widened difference is set exactly when acc < b.
  always_comb begin
    sum_ext    = {1'b0, acc} + {1'b0, b};
    dif_ext    = {1'b0, acc} - {1'b0, b};
    res_carry  = !op && sum_ext[WIDTH];
    res_borrow = op && dif_ext[WIDTH];
    res_acc    = op ? dif_ext[WIDTH-1:0] : sum_ext[WIDTH-1:0];
    res_sat    = 1'b0;
    if (SATURATE && res_carry) begin
      res_acc = '1;
      res_sat = 1'b1;
    end else if (SATURATE && res_borrow) begin
      res_acc = '0;
      res_sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      carry     <= 1'b0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
      sat       <= 1'b0;
      out_valid <= 1'b0;
      op_cnt    <= '0;
    end else if (clr) begin
      // Discards any pending result regardless of out_ready; op_cnt is kept.
      acc       <= '0;
      carry     <= 1'b0;
      borrow    <= 1'b0;
      zero      <= 1'b1;
      sat       <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      acc       <= res_acc;
      carry     <= res_carry;
      borrow    <= res_borrow;
      zero      <= (res_acc == '0);
      sat       <= res_sat;
      out_valid <= 1'b1;
      op_cnt    <= op_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addsub_accum.sv
// Scoreboard bench driving a wrapping and a saturating accumulator from the same operand stream.
module tb_addsub_accum;

  typedef struct packed {
    logic [3:0] acc;
    logic       carry;
    logic       borrow;
    logic       zero;
    logic       sat;
  } res_t;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, op, out_ready;
  logic [3:0] b;

  logic       in_ready_w, out_valid_w, carry_w, borrow_w, zero_w, sat_w;
  logic [3:0] acc_w;
  logic [7:0] cnt_w;
  logic       in_ready_s, out_valid_s, carry_s, borrow_s, zero_s, sat_s;
  logic [3:0] acc_s;
  logic [7:0] cnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  res_t       q_w[$];
  res_t       q_s[$];
  logic [3:0] m_acc_w, m_acc_s;
  logic       m_vld;
  logic [7:0] m_cnt;

  always #5 clk = ~clk;

  addsub_accum #(.WIDTH(4), .SATURATE(1'b0), .CNT_W(8)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_w),
    .op(op), .b(b), .out_valid(out_valid_w), .out_ready(out_ready),
    .acc(acc_w), .carry(carry_w), .borrow(borrow_w), .zero(zero_w), .sat(sat_w),
    .op_cnt(cnt_w)
  );

  addsub_accum #(.WIDTH(4), .SATURATE(1'b1), .CNT_W(8)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_s),
    .op(op), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
    .acc(acc_s), .carry(carry_s), .borrow(borrow_s), .zero(zero_s), .sat(sat_s),
    .op_cnt(cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic res_t calc(input logic [3:0] a, input logic sub, input logic [3:0] bb,
                                input bit satm);
    res_t r;
    int   s;
    r = '0;
    if (!sub) begin
      s       = int'(a) + int'(bb);
      r.carry = (s > 15);
    end else begin
      s        = int'(a) - int'(bb);
      r.borrow = (s < 0);
    end
    r.acc = 4'(s & 15);
    if (satm && r.carry) begin
      r.acc = 4'd15;
      r.sat = 1'b1;
    end else if (satm && r.borrow) begin
      r.acc = 4'd0;
      r.sat = 1'b1;
    end
    r.zero = (r.acc == 4'd0);
    return r;
  endfunction

  // One clock: drive, predict, advance, then compare against the model and scoreboard.
  task automatic cyc(input logic iv, input logic iop, input logic [3:0] ib,
                     input logic ordy, input logic iclr, input logic irst);
    logic exp_rdy;
    res_t rw, rs, ew, es;
    in_valid  = iv;
    op        = iop;
    b         = ib;
    out_ready = ordy;
    clr       = iclr;
    rst       = irst;
    #1;
    exp_rdy = !iclr && (!m_vld || ordy);
    if (!irst) begin
      check("in_ready_w", in_ready_w, exp_rdy);
      check("in_ready_s", in_ready_s, exp_rdy);
    end
    if (irst) begin
      m_acc_w = 0; m_acc_s = 0; m_vld = 0; m_cnt = 0;
      q_w.delete(); q_s.delete();
    end else if (iclr) begin
      m_acc_w = 0; m_acc_s = 0; m_vld = 0;
      q_w.delete(); q_s.delete();
    end else if (iv && exp_rdy) begin
      rw = calc(m_acc_w, iop, ib, 1'b0);
      rs = calc(m_acc_s, iop, ib, 1'b1);
      q_w.push_back(rw);
      q_s.push_back(rs);
      m_acc_w = rw.acc;
      m_acc_s = rs.acc;
      m_vld   = 1'b1;
      m_cnt   = m_cnt + 8'd1;
    end else if (m_vld && ordy) begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
    check("out_valid_w", out_valid_w, m_vld);
    check("out_valid_s", out_valid_s, m_vld);
    check("op_cnt_w", cnt_w, m_cnt);
    check("op_cnt_s", cnt_s, m_cnt);
    if (q_w.size() > 0) begin
      ew = q_w.pop_front();
      es = q_s.pop_front();
      check("res_w", {acc_w, carry_w, borrow_w, zero_w, sat_w}, ew);
      check("res_s", {acc_s, carry_s, borrow_s, zero_s, sat_s}, es);
    end
  endtask

  task automatic check_reset_state();
    check("rst_w", {acc_w, carry_w, borrow_w, zero_w, sat_w, out_valid_w, cnt_w}, 0);
    check("rst_s", {acc_s, carry_s, borrow_s, zero_s, sat_s, out_valid_s, cnt_s}, 0);
  endtask

  task automatic check_clear_state();
    check("clr_w", {acc_w, carry_w, borrow_w, zero_w, sat_w, out_valid_w}, 6'b0000_1_0_0_0 >> 0 == 0 ? 0 : {4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    check("clr_s", {acc_s, carry_s, borrow_s, zero_s, sat_s, out_valid_s}, {4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
  endtask

  initial begin
    m_acc_w = 0; m_acc_s = 0; m_vld = 0; m_cnt = 0;

    // Reset held two cycles with an operand presented.
    cyc(1, 0, 4'd5, 1, 0, 1);
    cyc(1, 0, 4'd5, 1, 0, 1);
    check_reset_state();
    rst = 0; in_valid = 0; clr = 0;
    #1;
    check("rdy_after_rst", in_ready_w, 1);

    // Wrapping add/sub sequence.
    cyc(1, 0, 4'd9, 1, 0, 0);
    check("wrap_add9", {acc_w, carry_w}, {4'd9, 1'b0});
    cyc(1, 0, 4'd9, 1, 0, 0);
    check("wrap_add9b", {acc_w, carry_w, zero_w}, {4'd2, 1'b1, 1'b0});
    cyc(1, 1, 4'd3, 1, 0, 0);
    check("wrap_sub3", {acc_w, borrow_w}, {4'd15, 1'b1});
    cyc(1, 1, 4'd15, 1, 0, 0);
    check("wrap_sub15", {acc_w, zero_w}, {4'd0, 1'b1});
    check("wrap_cnt", cnt_w, 4);

    // Saturation cases.
    cyc(0, 0, 4'd0, 1, 1, 0);
    check("clr_s", {acc_s, carry_s, borrow_s, zero_s, sat_s, out_valid_s},
          {4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    cyc(1, 0, 4'd12, 1, 0, 0);
    cyc(1, 0, 4'd7, 1, 0, 0);
    check("sat_add", {acc_s, sat_s, carry_s}, {4'd15, 1'b1, 1'b1});
    cyc(1, 1, 4'd5, 1, 0, 0);
    check("sat_sub", {acc_s, sat_s}, {4'd10, 1'b0});
    cyc(0, 0, 4'd0, 1, 1, 0);
    cyc(1, 0, 4'd3, 1, 0, 0);
    cyc(1, 1, 4'd5, 1, 0, 0);
    check("sat_under", {acc_s, sat_s, borrow_s, zero_s}, {4'd0, 1'b1, 1'b1, 1'b1});

    // Backpressure: held operand not taken until out_ready rises.
    cyc(0, 0, 4'd0, 1, 1, 0);
    cyc(1, 0, 4'd5, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 4'd4, 0, 0, 0);
      check("bp_acc", acc_w, 5);
    end
    cyc(1, 0, 4'd4, 1, 0, 0);
    check("bp_release", acc_w, 9);
    cyc(0, 0, 4'd0, 1, 0, 0);

    // Back-to-back accepts.
    cyc(0, 0, 4'd0, 1, 1, 0);
    for (int i = 1; i <= 4; i++) cyc(1, 0, 4'(i), 1, 0, 0);
    check("b2b_acc", acc_w, 10);

    // Clear colliding with a pending result and an offered operand.
    cyc(0, 0, 4'd0, 1, 1, 0);
    cyc(1, 0, 4'd7, 0, 0, 0);
    cyc(1, 0, 4'd2, 0, 1, 0);
    check("clr_col_w", {acc_w, zero_w, out_valid_w}, {4'd0, 1'b1, 1'b0});
    cyc(1, 0, 4'd2, 0, 0, 1);
    check_reset_state();

    // Random traffic with occasional clear.
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
